// File: rtl/dac.sv
// Behavioural 12-bit voltage-output DAC: converts the sampled code to a real
// voltage on each strobe and holds it until the next one.
module dac #(
   parameter real VREF  = 3.3,
   parameter int  WIDTH = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] I_data,
   output real              A_out,
   output logic [WIDTH-1:0] code,
   output logic             update
);

   localparam real FULL_SCALE = 2.0 ** WIDTH;

   // Declaration initialisers keep the output defined before the first reset.
   logic [WIDTH-1:0] code_q   = '0;
   real              a_q      = 0.0;
   logic             update_q = 1'b0;
   logic [WIDTH-1:0] data_clean;

   // Unknown input bits convert as 0 rather than poisoning the real output.
   always_comb begin
      data_clean = '0;
      for (int i = 0; i < WIDTH; i++)
         data_clean[i] = (I_data[i] === 1'b1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         code_q   <= '0;
         a_q      <= 0.0;
         update_q <= 1'b0;
      end else if (en) begin
         code_q   <= data_clean;
         a_q      <= VREF * real'(data_clean) / FULL_SCALE;
         update_q <= 1'b1;
      end else begin
         update_q <= 1'b0;
      end
   end

   assign A_out  = a_q;
   assign code   = code_q;
   assign update = update_q;

endmodule

// File: tb/tb_dac.sv
// Scoreboard bench for dac: stimulus pushes expected conversions, a monitor
// pops and compares them whenever update is presented.
module tb_dac;

   localparam real VREF = 3.3;
   localparam int  W    = 12;
   localparam real LSB  = 0.0008056640625;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         en  = 1'b0;
   logic [W-1:0] I_data = '0;
   real          A_out;
   logic [W-1:0] code;
   logic         update;

   dac #(VREF, W) dut (
      .clk(clk), .rst(rst), .en(en), .I_data(I_data),
      .A_out(A_out), .code(code), .update(update)
   );

   always #5 clk = ~clk;

   typedef struct {
      int  c;
      real v;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   bit   ref_mode = 1'b0;

   function automatic bit close(real a, real b);
      return ((a - b) < 1e-9) && ((b - a) < 1e-9);
   endfunction

   task automatic chk(input bit ok, input string name, input real act, input real req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0.13f expected %0.13f", name, act, req);
      end
   endtask

   // Reference: ideal unipolar DAC, LSB = VREF / 4096, no offset.
   function automatic real ideal_v(input int c);
      return (VREF / 4096.0) * c;
   endfunction

   // One clock of stimulus; a conversion is expected only when en wins over rst.
   task automatic step(input bit r, input bit e, input int d, input real v_req);
      rst = r; en = e; I_data = W'(d);
      @(posedge clk);
      if (e && !r) exp_q.push_back('{c: d & 12'hFFF, v: v_req});
      #1;
   endtask

   task automatic strobe(input int d);
      step(1'b0, 1'b1, d, ideal_v(d & 12'hFFF));
   endtask

   task automatic strobe_const(input int d, input real v);
      step(1'b0, 1'b1, d, v);
   endtask

   task automatic idle(input int n, input int d);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, d, 0.0);
   endtask

   task automatic chk_state(input string name, input real v, input int c, input bit u);
      chk(close(A_out, v), {name, " A_out"}, A_out, v);
      chk(int'(code) == c, {name, " code"}, real'(code), real'(c));
      chk(update == u, {name, " update"}, real'(update), real'(u));
   endtask

   // Monitor
   always @(negedge clk) begin
      if (update) begin
         if (exp_q.size() == 0) begin
            chk(1'b0, "unexpected update", real'(code), -1.0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk(int'(code) == e.c, "conv code", real'(code), real'(e.c));
            chk(close(A_out, e.v), "conv A_out", A_out, e.v);
         end
      end
   end

   initial begin
      real prev;
      int  base;

      // Power-up value before any reset
      #1;
      chk(close(A_out, 0.0), "powerup A_out", A_out, 0.0);

      // Reset held with an active strobe
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b1, 4000, 0.0);
         chk_state("reset", 0.0, 0, 1'b0);
      end

      // Single strobe, update high one cycle only
      strobe_const(4000, 3.22265625);
      chk_state("single", 3.22265625, 4000, 1'b1);
      idle(1, 1000);
      chk_state("single after", 3.22265625, 4000, 1'b0);

      // Hold while I_data moves with en low
      for (int i = 0; i < 200; i++) begin
         step(1'b0, 1'b0, $urandom_range(4095), 0.0);
         if (i % 50 == 49) chk_state("hold", 3.22265625, 4000, 1'b0);
      end
      strobe_const(1000, 0.8056640625);
      idle(2, 7);

      // Endpoints
      strobe_const(0, 0.0);
      strobe_const(4095, 3.2991943359375);
      strobe_const(2048, 1.65);
      idle(1, 0);
      chk_state("endpoint 2048", 1.65, 2048, 1'b0);

      // Back-to-back strobes: update stays high, output tracks with one cycle delay
      for (int i = 0; i < 5; i++) begin
         base = $urandom_range(4095);
         strobe(base);
         chk_state("b2b", ideal_v(base), base, 1'b1);
      end
      idle(1, 0);

      // Reset mid-run with en on the same edge
      strobe_const(2048, 1.65);
      idle(3, 0);
      step(1'b1, 1'b1, 4000, 0.0);
      chk_state("mid reset", 0.0, 0, 1'b0);
      strobe_const(1000, 0.8056640625);
      idle(1, 0);

      // Periodic tick: 400 us of 1 MHz strobes with a ramping code
      base = $urandom_range(3000);
      strobe(base);
      prev = A_out;
      for (int s = 1; s < 400; s++) begin
         idle(50, $urandom_range(4095));
         chk(close(A_out, prev), "tick hold", A_out, prev);
         idle(49, $urandom_range(4095));
         strobe(base + s);
         chk(close(A_out - prev, LSB), "tick step", A_out - prev, LSB);
         prev = A_out;
      end
      idle(2, 0);

      // Random traffic with occasional resets
      for (int i = 0; i < 400; i++) begin
         int  d;
         bit  r, e;
         d = $urandom_range(4095);
         r = ($urandom_range(99) < 4);
         e = $urandom_range(1);
         step(r, e, d, ideal_v(d));
         if (r) chk_state("rand reset", 0.0, 0, 1'b0);
      end
      idle(3, 0);

      chk(exp_q.size() == 0, "drain", real'(exp_q.size()), 0.0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
